// File: rtl/jtbubl_snd_pkg.sv
// Shared constants for the Bubble Bobble main/sound CPU latch.
// Holds the address decode values, status bit positions, the command FIFO
// depth and the sound-reset state encodings used by jtbubl_sndcomm.
package jtbubl_snd_pkg;

  // Main CPU register map
  localparam logic [1:0] MAIN_A_CMD  = 2'd0;
  localparam logic [1:0] MAIN_A_STAT = 2'd1;
  localparam logic [1:0] MAIN_A_SRST = 2'd2;

  // Sound CPU register map
  localparam logic [1:0] SND_A_CMD     = 2'd0;
  localparam logic [1:0] SND_A_NMI_OFF = 2'd1;
  localparam logic [1:0] SND_A_NMI_ON  = 2'd2;

  // Status byte bit positions
  localparam int ST_REP_BIT  = 0;
  localparam int ST_CMD_BIT  = 1;
  localparam int ST_FULL_BIT = 2;

  // Command FIFO geometry (only used when the FIFO is built in)
  localparam int FIFO_DEPTH = 4;
  localparam int FIFO_AW    = 2;

  typedef enum logic [1:0] {
    SRST_IDLE = 2'd0,
    SRST_HOLD = 2'd1,
    SRST_WAIT = 2'd2
  } srst_state_e;

  // Build the main-side status byte; unused bits read as zero
  function automatic logic [7:0] status_byte(input logic cmd_pend,
                                             input logic rep_pend,
                                             input logic full);
    logic [7:0] r;
    r              = 8'h00;
    r[ST_REP_BIT]  = rep_pend;
    r[ST_CMD_BIT]  = cmd_pend;
    r[ST_FULL_BIT] = full;
    return r;
  endfunction

endpackage

// File: rtl/jtbubl_sndcomm_fifo.sv
// Four-entry command FIFO between main and sound CPUs.
// A pop and a push in the same cycle on a full FIFO both take effect:
// the head leaves first, which frees the slot the push lands in.
module jtbubl_sndcomm_fifo
  import jtbubl_snd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_push,
  input  logic       i_pop,
  input  logic [7:0] i_din,
  output logic [7:0] o_head,
  output logic       o_empty,
  output logic       o_full
);

  localparam logic [FIFO_AW:0] L_DEPTH = (FIFO_AW+1)'(FIFO_DEPTH);

  logic [7:0]         r_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] r_rd_ptr;
  logic [FIFO_AW-1:0] r_wr_ptr;
  logic [FIFO_AW:0]   r_count;
  logic               w_do_pop;
  logic               w_do_push;

  assign w_do_pop  = i_pop & (r_count != {(FIFO_AW+1){1'b0}});
  assign w_do_push = i_push & ((r_count != L_DEPTH) | w_do_pop);

  assign o_head  = r_mem[r_rd_ptr];
  assign o_empty = (r_count == {(FIFO_AW+1){1'b0}});
  assign o_full  = (r_count == L_DEPTH);

  // Storage, pointers and occupancy update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= 8'h00;
      r_rd_ptr <= {FIFO_AW{1'b0}};
      r_wr_ptr <= {FIFO_AW{1'b0}};
      r_count  <= {(FIFO_AW+1){1'b0}};
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_din;
        r_wr_ptr        <= r_wr_ptr + FIFO_AW'(1);
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (FIFO_AW+1)'(1);
        2'b01:   r_count <= r_count - (FIFO_AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/jtbubl_sndcomm.sv
// Main/sound CPU communication latch with sound-CPU reset control.
// Main writes a command, sound writes a reply; each side sees a pending
// flag that clears on the first read edge of the other side's data.
// Optional: define JTBUBL_SNDCOMM_FIFO_EN to queue up to four commands.
module jtbubl_sndcomm
  import jtbubl_snd_pkg::*;
#(
  parameter int RST_HOLD = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       main_cen,
  input  logic [1:0] main_addr,
  input  logic       main_wr,
  input  logic       main_rd,
  input  logic [7:0] main_din,
  output logic [7:0] main_dout,
  input  logic       snd_cen,
  input  logic [1:0] snd_addr,
  input  logic       snd_wr,
  input  logic       snd_rd,
  input  logic [7:0] snd_din,
  output logic [7:0] snd_dout,
  output logic       snd_nmi_n,
  output logic       snd_rst
);

  localparam int            CW        = $clog2(RST_HOLD + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(RST_HOLD - 1);

  srst_state_e   r_state;
  logic [CW-1:0] r_cnt;
  logic          r_snd_rst;
  logic          r_bit0;
  logic          r_nmi_en;
  logic          r_nmi_n;
  logic [7:0]    r_reply;
  logic          r_rep_pend;
  logic          r_main_rd_l;
  logic          r_snd_rd_l;

  logic w_main_we, w_main_cmd_we, w_main_srst_we;
  logic w_snd_we, w_snd_rep_we, w_snd_nmi_off, w_snd_nmi_on;
  logic w_snd_rd_edge, w_main_rd_edge;
  logic w_cmd_pend, w_cmd_full, w_rep_pend, w_nmi_en;
  logic [7:0] w_cmd_data;

  assign w_main_we      = main_cen & main_wr;
  assign w_main_cmd_we  = w_main_we & (main_addr == MAIN_A_CMD);
  assign w_main_srst_we = w_main_we & (main_addr == MAIN_A_SRST);

  // Sound-side writes are ignored while the sound CPU is held in reset
  assign w_snd_we      = snd_cen & snd_wr & ~r_snd_rst;
  assign w_snd_rep_we  = w_snd_we & (snd_addr == SND_A_CMD);
  assign w_snd_nmi_off = w_snd_we & (snd_addr == SND_A_NMI_OFF);
  assign w_snd_nmi_on  = w_snd_we & (snd_addr == SND_A_NMI_ON);

  assign w_snd_rd_edge  = snd_rd  & ~r_snd_rd_l  & (snd_addr  == SND_A_CMD);
  assign w_main_rd_edge = main_rd & ~r_main_rd_l & (main_addr == MAIN_A_CMD);

  // Reset forces these low immediately, not one cycle after snd_rst rises
  assign w_rep_pend = r_rep_pend & ~r_snd_rst;
  assign w_nmi_en   = r_nmi_en & ~r_snd_rst;

  assign snd_rst   = r_snd_rst;
  assign snd_nmi_n = r_nmi_n;

  // Previous read strobes, so a long read clears a flag only once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main_rd_l <= 1'b0;
      r_snd_rd_l  <= 1'b0;
    end else begin
      r_main_rd_l <= main_rd;
      r_snd_rd_l  <= snd_rd;
    end
  end

`ifdef JTBUBL_SNDCOMM_FIFO_EN
  logic w_fifo_empty;

  jtbubl_sndcomm_fifo u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_main_cmd_we),
    .i_pop   (w_snd_rd_edge),
    .i_din   (main_din),
    .o_head  (w_cmd_data),
    .o_empty (w_fifo_empty),
    .o_full  (w_cmd_full)
  );

  assign w_cmd_pend = ~w_fifo_empty;
`else
  logic [7:0] r_cmd;
  logic       r_cmd_pend;

  // Single command register; a write wins over a simultaneous read edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cmd      <= 8'h00;
      r_cmd_pend <= 1'b0;
    end else if (w_main_cmd_we) begin
      r_cmd      <= main_din;
      r_cmd_pend <= 1'b1;
    end else if (w_snd_rd_edge) begin
      r_cmd_pend <= 1'b0;
    end
  end

  assign w_cmd_data = r_cmd;
  assign w_cmd_pend = r_cmd_pend;
  assign w_cmd_full = 1'b0;
`endif

  // Reply register and its pending flag; a write wins over a read edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_reply    <= 8'h00;
      r_rep_pend <= 1'b0;
    end else begin
      if (w_snd_rep_we) r_reply <= snd_din;
      if (r_snd_rst)           r_rep_pend <= 1'b0;
      else if (w_snd_rep_we)   r_rep_pend <= 1'b1;
      else if (w_main_rd_edge) r_rep_pend <= 1'b0;
    end
  end

  // NMI enable and the registered NMI line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_nmi_en <= 1'b0;
      r_nmi_n  <= 1'b1;
    end else begin
      if (r_snd_rst)          r_nmi_en <= 1'b0;
      else if (w_snd_nmi_on)  r_nmi_en <= 1'b1;
      else if (w_snd_nmi_off) r_nmi_en <= 1'b0;
      r_nmi_n <= ~(w_cmd_pend & w_nmi_en);
    end
  end

  // Last bit0 the main CPU wrote to the sound-reset control address
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 r_bit0 <= 1'b0;
    else if (w_main_srst_we) r_bit0 <= main_din[0];
  end

  // Sound-reset sequencer: fixed minimum pulse, then follow bit0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= SRST_HOLD;
      r_cnt     <= {CW{1'b0}};
      r_snd_rst <= 1'b1;
    end else begin
      case (r_state)
        SRST_IDLE: begin
          if (w_main_srst_we && main_din[0]) begin
            r_state   <= SRST_HOLD;
            r_cnt     <= {CW{1'b0}};
            r_snd_rst <= 1'b1;
          end
        end
        SRST_HOLD: begin
          if (r_cnt == HOLD_LAST) begin
            r_state   <= r_bit0 ? SRST_WAIT : SRST_IDLE;
            r_snd_rst <= r_bit0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        SRST_WAIT: begin
          if (!r_bit0) begin
            r_state   <= SRST_IDLE;
            r_snd_rst <= 1'b0;
          end
        end
        default: begin
          r_state   <= SRST_IDLE;
          r_cnt     <= {CW{1'b0}};
          r_snd_rst <= 1'b0;
        end
      endcase
    end
  end

  // Main CPU read mux
  always_comb begin
    main_dout = 8'hFF;
    case (main_addr)
      MAIN_A_CMD:  main_dout = r_reply;
      MAIN_A_STAT: main_dout = status_byte(w_cmd_pend, w_rep_pend, w_cmd_full);
      default:     main_dout = 8'hFF;
    endcase
  end

  // Sound CPU read mux
  always_comb begin
    snd_dout = 8'hFF;
    if (snd_addr == SND_A_CMD) snd_dout = w_cmd_data;
    else                       snd_dout = 8'hFF;
  end

endmodule
